booth_control: RTL and testbench
================================

Name: booth_control

Overview:
- Sequencing controller plus datapath for a radix-2 Booth signed multiplier.
- Operands and the start request arrive already synchronized through the two-flop input chains.
- On a rising edge of the synchronized start level, the block captures both operands and runs one Booth iteration per clock for ancho cycles.
- It then presents a held 2*ancho-bit product with a one-cycle completion pulse, for the display or readout stage.

Parameters:
- ancho, 4, operand width in bits (signed two's complement); must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- inicio  input  1  synchronized start level; a 0->1 transition requests a multiplication.
- multiplicando  input  ancho  signed multiplicand M, sampled on the capture edge.
- multiplicador  input  ancho  signed multiplier Q, sampled on the capture edge.
- ocupado  output  1  high while a multiplication is in progress (CALC or FIN).
- listo  output  1  one-cycle completion pulse.
- producto  output  2*ancho  signed product, held until the next completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, producto=0, listo=0, ocupado=0, iteration counter=0.
  - inicio_prev=1, so a start level already high at reset release does not trigger.
- Edge detect:
  - arranque = inicio & ~inicio_prev.
  - inicio_prev <= inicio every cycle, in every state.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - If arranque: load A=0 (ancho+1 bits), Q=multiplicador, q_1=0, M=sign-extended multiplicando (ancho+1 bits), cnt=0; go to CALC.
  - This edge is the capture edge E0.
- CALC, one iteration per edge:
  - {Q[0],q_1}=01: A=A+M.
  - {Q[0],q_1}=10: A=A-M.
  - {Q[0],q_1}=00 or 11: A unchanged.
  - Then arithmetic shift right of {A,Q,q_1} by one; the sign bit of A is replicated.
  - cnt increments each iteration.
  - On the edge performing iteration ancho (cnt==ancho-1): producto <= {A_next[ancho-1:0], Q_next}; go to FIN.
- FIN: listo=1 for exactly this cycle; the next edge returns to IDLE.
- Outputs:
  - ocupado is a registered output, high in CALC and FIN.
  - listo is high only in FIN.
- Latency:
  - listo and the new producto are visible in the cycle after edge E_ancho (e.g. E4 for ancho=4).
  - Next capture possible at E_(ancho+2) at the earliest.
- Arithmetic width:
  - A is ancho+1 bits so that A-M with M=-2^(ancho-1) does not overflow.
  - The final product fits in 2*ancho bits for all operand pairs.
- Boundary conditions:
  - arranque in CALC or FIN is ignored and not queued.
  - A start level held high across completion does not retrigger; a new 0->1 transition is required.
  - Operand changes after E0 have no effect.
  - producto keeps its previous value during CALC and changes only on the completion edge.
  - rst asserted mid-CALC aborts immediately: producto=0, state=IDLE, no listo pulse.
  - Operand 0 on either side gives producto=0.

Decomposition:
- Package booth_pkg:
  - state enum estado_t {IDLE, CALC, FIN}.
  - Booth pair encodings as localparams (SUMA=2'b01, RESTA=2'b10).
- One combinational sub-module booth_paso (parameter ancho):
  - Inputs: A, Q, q_1, M.
  - Outputs: next A, Q, q_1 after one add/sub-and-shift.
  - booth_control owns the FSM, counter, edge detector and output registers.

Test Plan:
- ancho=4, M=3, Q=2, single inicio 0->1 -> listo pulses once in the cycle after E4; producto=8'h06; ocupado high E0..E5.
- M=-3, Q=5 -> producto=8'hF1 (-15); M=7, Q=-8 -> producto=8'hC8 (-56).
- M=-8, Q=-8 -> producto=8'h40 (+64); confirms A guard bit.
- inicio held high for 20 cycles -> exactly one listo pulse; toggle inicio low then high -> second multiplication runs.
- Second inicio rise at E2 with different operands -> ignored; producto reflects the first operands only; a single listo pulse.
- rst=0 asserted at E2 (mid-CALC) with inicio high at release -> outputs 0 immediately, no listo pulse, no spurious start after release.

Source files
------------

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module : booth_pkg
// Brief  : Shared types and Booth recoding constants for booth_control.
// Rev    : 1.0
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } estado_t;

    // {Q[0], q_1} pairs that select an add or a subtract of M
    localparam logic [1:0] SUMA  = 2'b01;
    localparam logic [1:0] RESTA = 2'b10;

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_control_if.sv
`default_nettype none
// ============================================================================
// Module : booth_control_if
// Brief  : Start/operand/result bundle between a requester and booth_control.
// Rev    : 1.0
// ============================================================================
interface booth_control_if #(
    parameter int ancho = 4
) ();
    logic                    inicio;
    logic signed [ancho-1:0] multiplicando;
    logic signed [ancho-1:0] multiplicador;
    logic                    ocupado;
    logic                    listo;
    logic [2*ancho-1:0]      producto;

    modport master (
        output inicio, multiplicando, multiplicador,
        input  ocupado, listo, producto
    );

    modport slave (
        input  inicio, multiplicando, multiplicador,
        output ocupado, listo, producto
    );
endinterface : booth_control_if
`default_nettype wire

// File: rtl/booth_paso.sv
`default_nettype none
// ============================================================================
// Module : booth_paso
// Brief  : One radix-2 Booth step: conditional add/sub of M, then ASR of {A,Q,q_1}.
// Rev    : 1.0
// ============================================================================
module booth_paso
    import booth_pkg::*;
#(
    parameter int ancho = 4
) (
    input  wire logic [ancho:0]   a,
    input  wire logic [ancho-1:0] q,
    input  wire logic             q_1,
    input  wire logic [ancho:0]   m,
    output logic      [ancho:0]   a_next,
    output logic      [ancho-1:0] q_next,
    output logic                  q_1_next
);
    logic [ancho:0] w_suma;

    always_comb begin
        w_suma = a;
        case ({q[0], q_1})
            SUMA:    w_suma = a + m;
            RESTA:   w_suma = a - m;
            default: w_suma = a;
        endcase
    end

    assign a_next   = {w_suma[ancho], w_suma[ancho:1]};
    assign q_next   = {w_suma[0], q[ancho-1:1]};
    assign q_1_next = q[0];

endmodule : booth_paso
`default_nettype wire

// File: rtl/booth_control.sv
`default_nettype none
// ============================================================================
// Module : booth_control
// Brief  : Radix-2 Booth signed multiplier sequencer with held product output.
// Rev    : 1.0
// ============================================================================
module booth_control
    import booth_pkg::*;
#(
    parameter int ancho = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    booth_control_if.slave  bus
);
    localparam int c_CNT_W = $clog2(ancho) + 1;

    estado_t              r_state;
    estado_t              w_state_next;
    logic                 r_inicio_prev;
    logic                 w_arranque;
    logic [ancho:0]       r_a;
    logic [ancho:0]       r_m;
    logic [ancho-1:0]     r_q;
    logic                 r_q1;
    logic [ancho:0]       w_a_next;
    logic [ancho-1:0]     w_q_next;
    logic                 w_q1_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_ultimo;
    logic [2*ancho-1:0]   r_producto;
    logic                 r_ocupado;
    logic                 w_listo;

    assign w_arranque = bus.inicio & ~r_inicio_prev;
    assign w_ultimo   = (r_cnt == c_CNT_W'(ancho - 1));

    booth_paso #(.ancho(ancho)) u_paso (
        .a        (r_a),
        .q        (r_q),
        .q_1      (r_q1),
        .m        (r_m),
        .a_next   (w_a_next),
        .q_next   (w_q_next),
        .q_1_next (w_q1_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_arranque) w_state_next = CALC;
            CALC:    if (w_ultimo)   w_state_next = FIN;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_listo = (r_state == FIN);
    end

    // inicio_prev resets high so a level already asserted at release is not a start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inicio_prev <= 1'b1;
            r_ocupado     <= 1'b0;
            r_a           <= '0;
            r_m           <= '0;
            r_q           <= '0;
            r_q1          <= 1'b0;
            r_cnt         <= '0;
            r_producto    <= '0;
        end else begin
            r_inicio_prev <= bus.inicio;
            r_ocupado     <= (w_state_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_arranque) begin
                        r_a   <= '0;
                        r_m   <= {bus.multiplicando[ancho-1], bus.multiplicando};
                        r_q   <= bus.multiplicador;
                        r_q1  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                CALC: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_q1  <= w_q1_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_ultimo) r_producto <= {w_a_next[ancho-1:0], w_q_next};
                end
                default: ;
            endcase
        end
    end

    assign bus.ocupado  = r_ocupado;
    assign bus.listo    = w_listo;
    assign bus.producto = r_producto;

endmodule : booth_control
`default_nettype wire

// File: tb/tb_booth_control.sv
`default_nettype none
// ============================================================================
// Module : tb_booth_control
// Brief  : Self-checking bench for booth_control against an integer-multiply model.
// Rev    : 1.0
// ============================================================================
module tb_booth_control;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    booth_control_if #(.ancho(W)) bus ();

    booth_control #(.ancho(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Results of the most recent do_mult run
    logic [2*W-1:0] prev_prod;
    int             n_listo;
    int             first_listo;
    bit             busy_bad;
    bit             held_bad;

    function automatic logic [2*W-1:0] model(input logic signed [W-1:0] m, input logic signed [W-1:0] q);
        int p;
        p = int'(m) * int'(q);
        return p[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full multiplication and records what was observed; no checking here
    task automatic do_mult(input logic signed [W-1:0] m, input logic signed [W-1:0] q, input bit keep_high);
        prev_prod = bus.producto;
        bus.inicio = 1'b0;
        tick();
        bus.multiplicando = m;
        bus.multiplicador = q;
        bus.inicio = 1'b1;
        tick();
        bus.multiplicando = W'($urandom);
        bus.multiplicador = W'($urandom);
        n_listo = 0; first_listo = -1; busy_bad = 1'b0; held_bad = 1'b0;
        for (int j = 0; j <= W + 3; j++) begin
            if (j > 0) tick();
            if (bus.listo === 1'b1) begin
                n_listo++;
                if (first_listo < 0) first_listo = j;
            end
            if (bus.ocupado !== (j <= W)) busy_bad = 1'b1;
            if (j < W && bus.producto !== prev_prod) held_bad = 1'b1;
        end
        if (!keep_high) bus.inicio = 1'b0;
    endtask

    task automatic check_run(input string name, input logic [2*W-1:0] exp);
        n_cmp++;
        if (bus.producto !== exp) begin
            n_fail++;
            $display("FAIL %s producto: got %h expected %h", name, bus.producto, exp);
        end
        n_cmp++;
        if (n_listo !== 1 || first_listo !== W) begin
            n_fail++;
            $display("FAIL %s listo: got count=%0d at=%0d expected count=1 at=%0d", name, n_listo, first_listo, W);
        end
        n_cmp++;
        if (busy_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ocupado: got bad window expected high for E0..E%0d only", name, W + 1);
        end
        n_cmp++;
        if (held_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold: got producto change during CALC expected %h held", name, prev_prod);
        end
    endtask

    task automatic test_reset();
        int bad;
        bus.inicio = 1'b1;
        bus.multiplicando = 4'sd3;
        bus.multiplicador = 4'sd3;
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if (bus.producto !== '0 || bus.listo !== 1'b0 || bus.ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got prod=%h listo=%b ocupado=%b expected 0/0/0",
                     bus.producto, bus.listo, bus.ocupado);
        end
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.ocupado !== 1'b0 || bus.listo !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_release_high: got %0d busy cycles expected 0", bad);
        end
    endtask

    task automatic test_directed();
        logic signed [W-1:0] ms [8] = '{4'sd3, -4'sd3, 4'sd7, -4'sd8, 4'sd0, -4'sd5, 4'sd7, -4'sd8};
        logic signed [W-1:0] qs [8] = '{4'sd2, 4'sd5, -4'sd8, -4'sd8, -4'sd7, 4'sd0, 4'sd7, 4'sd7};
        for (int i = 0; i < 8; i++) begin
            do_mult(ms[i], qs[i], 1'b0);
            check_run($sformatf("directed%0d", i), model(ms[i], qs[i]));
        end
    endtask

    task automatic test_random();
        logic signed [W-1:0] m, q;
        for (int i = 0; i < 24; i++) begin
            m = W'($urandom);
            q = W'($urandom);
            do_mult(m, q, 1'b0);
            check_run($sformatf("random%0d", i), model(m, q));
        end
    endtask

    task automatic test_hold_high();
        int extra;
        do_mult(4'sd3, 4'sd5, 1'b1);
        check_run("hold_first", model(4'sd3, 4'sd5));
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.listo === 1'b1 || bus.ocupado === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL hold_retrigger: got %0d busy cycles expected 0", extra);
        end
        do_mult(-4'sd2, 4'sd7, 1'b0);
        check_run("hold_second", model(-4'sd2, 4'sd7));
    endtask

    task automatic test_back_to_back();
        int cnt, idle_bad;
        bus.inicio = 1'b0;
        tick();
        bus.multiplicando = 4'sd5;
        bus.multiplicador = -4'sd3;
        bus.inicio = 1'b1;
        tick();                       // E0 seen
        bus.inicio = 1'b0;
        tick();                       // after E1
        bus.multiplicando = 4'sd7;
        bus.multiplicador = 4'sd7;
        bus.inicio = 1'b1;            // rises at E2
        cnt = 0;
        for (int j = 2; j <= W + 8; j++) begin
            tick();
            if (bus.listo === 1'b1) cnt++;
        end
        n_cmp++;
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL midcalc_listo: got %0d pulses expected 1", cnt);
        end
        n_cmp++;
        if (bus.producto !== model(4'sd5, -4'sd3)) begin
            n_fail++;
            $display("FAIL midcalc_producto: got %h expected %h", bus.producto, model(4'sd5, -4'sd3));
        end
        idle_bad = (bus.ocupado !== 1'b0) ? 1 : 0;
        n_cmp++;
        if (idle_bad != 0) begin
            n_fail++;
            $display("FAIL midcalc_queued: got ocupado=%b expected 0", bus.ocupado);
        end
    endtask

    task automatic test_abort();
        int bad;
        bus.inicio = 1'b0;
        tick();
        bus.multiplicando = 4'sd6;
        bus.multiplicador = 4'sd5;
        bus.inicio = 1'b1;
        tick();                       // after E0
        tick();                       // after E1
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.producto !== '0 || bus.ocupado !== 1'b0 || bus.listo !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: got prod=%h ocupado=%b listo=%b expected 0/0/0",
                     bus.producto, bus.ocupado, bus.listo);
        end
        tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < W + 6; i++) begin
            tick();
            if (bus.listo !== 1'b0 || bus.ocupado !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || bus.producto !== '0) begin
            n_fail++;
            $display("FAIL abort_release: got %0d busy cycles prod=%h expected 0 and 00", bad, bus.producto);
        end
        do_mult(-4'sd4, 4'sd3, 1'b0);
        check_run("after_abort", model(-4'sd4, 4'sd3));
    endtask

    initial begin
        bus.inicio = 1'b0;
        bus.multiplicando = '0;
        bus.multiplicador = '0;
        test_reset();
        test_directed();
        test_random();
        test_hold_high();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_booth_control
`default_nettype wire
